// File: rtl/fp8_pkg.sv
// Shared fp8 definitions (sign[7], exp[6:4] bias 3, mant[3:0]) used by the fp8 arithmetic blocks.
package fp8_pkg;

    localparam int EXP_W      = 3;
    localparam int MANT_W     = 4;
    localparam int SIG_W      = MANT_W + 1;
    localparam int EEXP_W     = 6;
    localparam int Q_W        = 6;
    localparam int DIV_CYCLES = 6;
    localparam int CNT_W      = 3;
    localparam int BIAS       = 3;

    localparam logic [7:0] FP8_INF  = 8'h70;
    localparam logic [7:0] FP8_QNAN = 8'h78;
    localparam logic [7:0] FP8_ZERO = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        PACK = 2'd2
    } state_t;

    // Operand after classification; sig always has bit4 set unless the operand is zero.
    typedef struct packed {
        logic                     sign;
        logic                     zero;
        logic                     inf;
        logic                     nan;
        logic [SIG_W-1:0]         sig;
        logic signed [EEXP_W-1:0] eexp;
    } fp8_fields_t;

endpackage

// File: rtl/fp8_unpack.sv
// Classifies an fp8 operand and normalizes subnormals so the significand always has its MSB set.
module fp8_unpack
    import fp8_pkg::*;
(
    input  logic [7:0]  op,
    output fp8_fields_t fields
);

    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant_f;
    logic [2:0]        lz;

    assign exp_f  = op[6:4];
    assign mant_f = op[3:0];

    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        lz = 3'd0;
        casez (mant_f)
            4'b1???: lz = 3'd1;
            4'b01??: lz = 3'd2;
            4'b001?: lz = 3'd3;
            4'b0001: lz = 3'd4;
            default: lz = 3'd0;
        endcase

        fields.sign = op[7];
        fields.zero = (op[6:0] == 7'd0);
        fields.inf  = (exp_f == 3'd7) && (mant_f == 4'd0);
        fields.nan  = (exp_f == 3'd7) && (mant_f != 4'd0);

        if (exp_f == 3'd0) begin
            // Subnormal: hidden bit 0, effective exponent 1, then shift the leading one up to bit4.
            fields.sig  = SIG_W'({1'b0, mant_f} << lz);
            fields.eexp = 6'sd1 - EEXP_W'(lz);
        end else begin
            fields.sig  = {1'b1, mant_f};
            fields.eexp = EEXP_W'(exp_f);
        end
    end

endmodule

// File: rtl/fp_div_8bit_seq.sv
// Sequential fp8 divider: specials resolved at accept, otherwise a 6-cycle restoring divide then pack.
module fp_div_8bit_seq
    import fp8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic [7:0] result,
    output logic       done,
    output logic       busy,
    output logic       dz,
    output logic       inv
);

    state_t      state, state_nxt;
    fp8_fields_t fa, fb;

    logic       armed, accept, res_sign;
    logic       spec_hit, spec_dz, spec_inv;
    logic [7:0] spec_res;

    logic                     sign_q, spec_q, spec_dz_q, spec_inv_q;
    logic [7:0]               spec_res_q;
    logic signed [EEXP_W-1:0] e_base_q;
    logic [SIG_W-1:0]         div_b_q;
    logic [Q_W-1:0]           rem_q, quo_q;
    logic [CNT_W-1:0]         cnt_q;

    logic                     q_bit;
    logic [Q_W-1:0]           rem_diff;
    logic signed [EEXP_W-1:0] e_adj;
    logic [EEXP_W-1:0]        sub_sh;
    logic [MANT_W-1:0]        mant;
    logic [7:0]               pack_res;

    fp8_unpack u_unpack_a (.op(op_a), .fields(fa));
    fp8_unpack u_unpack_b (.op(op_b), .fields(fb));

    assign res_sign = fa.sign ^ fb.sign;
    assign accept   = (state == IDLE) && start && armed;
    assign busy     = (state != IDLE) || done;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = FP8_ZERO;
        spec_dz  = 1'b0;
        spec_inv = 1'b0;
        if (fa.nan || fb.nan || (fa.zero && fb.zero) || (fa.inf && fb.inf)) begin
            spec_res = FP8_QNAN;
            spec_inv = 1'b1;
        end else if (fa.inf || fb.zero) begin
            spec_res = {res_sign, FP8_INF[6:0]};
            spec_dz  = fb.zero;
        end else if (fa.zero || fb.inf) begin
            spec_res = FP8_ZERO;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // The first edge after reset release only arms the block, so a start there is not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = spec_hit ? PACK : DIV;
            DIV:     if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_nxt = PACK;
            PACK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign q_bit    = (rem_q >= {1'b0, div_b_q});
    assign rem_diff = q_bit ? (rem_q - {1'b0, div_b_q}) : rem_q;

    // Quotient in [16,62]: a set q[5] means the significand ratio was >= 1.
    always_comb begin
        pack_res = FP8_ZERO;
        if (quo_q[Q_W-1]) begin
            mant  = quo_q[4:1];
            e_adj = e_base_q;
        end else begin
            mant  = quo_q[3:0];
            e_adj = e_base_q - 6'sd1;
        end
        sub_sh = EEXP_W'(6'sd1 - e_adj);
        if (e_adj >= 6'sd7) begin
            pack_res = {sign_q, FP8_INF[6:0]};
        end else if (e_adj <= 6'sd0) begin
            if (sub_sh < 6'd5) pack_res = {sign_q, 3'b000, MANT_W'({1'b1, mant} >> sub_sh)};
        end else begin
            pack_res = {sign_q, e_adj[EXP_W-1:0], mant};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: datapath registers are small flops, not a memory, so all of them are cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= FP8_ZERO;
            done       <= 1'b0;
            dz         <= 1'b0;
            inv        <= 1'b0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= FP8_ZERO;
            spec_dz_q  <= 1'b0;
            spec_inv_q <= 1'b0;
            e_base_q   <= '0;
            div_b_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q     <= res_sign;
                        spec_q     <= spec_hit;
                        spec_res_q <= spec_res;
                        spec_dz_q  <= spec_dz;
                        spec_inv_q <= spec_inv;
                        e_base_q   <= fa.eexp - fb.eexp + $signed(EEXP_W'(BIAS));
                        div_b_q    <= fb.sig;
                        rem_q      <= {1'b0, fa.sig};
                        quo_q      <= '0;
                        cnt_q      <= '0;
                    end
                end
                DIV: begin
                    rem_q <= rem_diff << 1;
                    quo_q <= {quo_q[Q_W-2:0], q_bit};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                PACK: begin
                    result <= spec_q ? spec_res_q : pack_res;
                    dz     <= spec_q & spec_dz_q;
                    inv    <= spec_q & spec_inv_q;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_8bit_seq.sv
// Self-checking bench for fp_div_8bit_seq: directed vector table, random operands against a value model, corner sequences.
module tb_fp_div_8bit_seq;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [7:0] op_a, op_b, result;
    logic       done, busy, dz, inv;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       dz;
        logic       inv;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fp_div_8bit_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .result(result), .done(done), .busy(busy), .dz(dz), .inv(inv)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [7:0] a, b, r, input logic d, iv, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.res = r; v.dz = d; v.inv = iv; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Value model: exact quotient in units of 2^-6 (the subnormal step), truncated toward zero.
    function automatic void ref_div(input logic [7:0] a, b, output logic [7:0] r,
                                    output logic d, output logic iv, output int lat);
        int  siga, sigb, ea, eb, units, p;
        logic s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        s      = a[7] ^ b[7];
        a_zero = (a[6:0] == 0);
        b_zero = (b[6:0] == 0);
        a_inf  = (a[6:4] == 7) && (a[3:0] == 0);
        b_inf  = (b[6:4] == 7) && (b[3:0] == 0);
        a_nan  = (a[6:4] == 7) && (a[3:0] != 0);
        b_nan  = (b[6:4] == 7) && (b[3:0] != 0);
        d = 1'b0; iv = 1'b0; lat = 1;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            r = 8'h78; iv = 1'b1;
        end else if (a_inf || b_zero) begin
            r = {s, 7'h70}; d = b_zero;
        end else if (a_zero || b_inf) begin
            r = 8'h00;
        end else begin
            lat  = 7;
            siga = (a[6:4] == 0) ? int'(a[3:0]) : 16 + int'(a[3:0]);
            sigb = (b[6:4] == 0) ? int'(b[3:0]) : 16 + int'(b[3:0]);
            ea   = (a[6:4] == 0) ? 1 : int'(a[6:4]);
            eb   = (b[6:4] == 0) ? 1 : int'(b[6:4]);
            units = (siga << (ea - eb + 6)) / sigb;
            if (units >= 1024) begin
                r = {s, 7'h70};
            end else if (units == 0) begin
                r = 8'h00;
            end else if (units < 16) begin
                r = {s, 3'b000, 4'(units)};
            end else begin
                p = 4;
                while ((units >> (p + 1)) != 0) p++;
                r = {s, 3'(p - 3), 4'((units >> (p - 4)) & 15)};
            end
        end
    endfunction

    // Issues one operation, scrambles the operand inputs after accept, and times the done pulse.
    task automatic do_op(input logic [7:0] a, b, output logic [7:0] r, output logic d, iv,
                         output int lat, output logic busy_done, busy_after, done_after);
        r = 'x; d = 'x; iv = 'x; lat = -1; busy_done = 'x;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = 8'($urandom);
        op_b = 8'($urandom);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k; r = result; d = dz; iv = inv; busy_done = busy;
                break;
            end
        end
        @(posedge clk); #1;
        busy_after = busy;
        done_after = done;
    endtask

    initial begin
        logic [7:0] r, er;
        logic       d, iv, ed, eiv, bd, ba, da;
        int         lat, elat, n_done;
        logic [7:0] seen [2];

        rst_n = 1'b0; start = 1'b0; op_a = 8'h00; op_b = 8'h00;

        add_vec(8'h48, 8'h38, 8'h40, 1'b0, 1'b0, 7);
        add_vec(8'h30, 8'h38, 8'h25, 1'b0, 1'b0, 7);
        add_vec(8'hC8, 8'h38, 8'hC0, 1'b0, 1'b0, 7);
        add_vec(8'h30, 8'h00, 8'h70, 1'b1, 1'b0, 1);
        add_vec(8'h00, 8'h00, 8'h78, 1'b0, 1'b1, 1);
        add_vec(8'h6F, 8'h10, 8'h70, 1'b0, 1'b0, 7);
        add_vec(8'h10, 8'h6F, 8'h01, 1'b0, 1'b0, 7);
        add_vec(8'h01, 8'h6F, 8'h00, 1'b0, 1'b0, 7);
        add_vec(8'h7F, 8'h38, 8'h78, 1'b0, 1'b1, 1);
        add_vec(8'h70, 8'hF0, 8'h78, 1'b0, 1'b1, 1);
        add_vec(8'h70, 8'h00, 8'h70, 1'b1, 1'b0, 1);
        add_vec(8'hB0, 8'h00, 8'hF0, 1'b1, 1'b0, 1);
        add_vec(8'hF0, 8'h38, 8'hF0, 1'b0, 1'b0, 1);
        add_vec(8'h80, 8'h38, 8'h00, 1'b0, 1'b0, 1);
        add_vec(8'h38, 8'hF0, 8'h00, 1'b0, 1'b0, 1);
        add_vec(8'hB8, 8'h01, 8'hF0, 1'b0, 1'b0, 7);

        #12;
        check("reset result", result, 8'h00);
        check("reset done", done, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset dz", dz, 1'b0);
        check("reset inv", inv, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, r, d, iv, lat, bd, ba, da);
            check($sformatf("vec%0d %h/%h result", i, vecs[i].a, vecs[i].b), r, vecs[i].res);
            check($sformatf("vec%0d dz", i), d, vecs[i].dz);
            check($sformatf("vec%0d inv", i), iv, vecs[i].inv);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d busy at done", i), bd, 1'b1);
            check($sformatf("vec%0d busy after", i), ba, 1'b0);
            check($sformatf("vec%0d done width", i), da, 1'b0);
        end

        for (int i = 0; i < 150; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            ref_div(a, b, er, ed, eiv, elat);
            do_op(a, b, r, d, iv, lat, bd, ba, da);
            check($sformatf("rand %h/%h result", a, b), r, er);
            check($sformatf("rand %h/%h dz", a, b), d, ed);
            check($sformatf("rand %h/%h inv", a, b), iv, eiv);
            check($sformatf("rand %h/%h latency", a, b), lat, elat);
        end

        // Start pulsed while dividing must be ignored.
        @(negedge clk);
        op_a = 8'h48; op_b = 8'h38; start = 1'b1;
        @(posedge clk); #1;
        n_done = 0; lat = -1; r = 'x; d = 'x;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                start = 1'b1; op_a = 8'h30; op_b = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (lat < 0) begin lat = k; r = result; d = dz; end
            end
        end
        check("start in DIV result", r, 8'h40);
        check("start in DIV dz", d, 1'b0);
        check("start in DIV latency", lat, 7);
        check("start in DIV done count", n_done, 1);

        // Reset in the middle of a division: flags from the previous op must clear too.
        do_op(8'h30, 8'h00, r, d, iv, lat, bd, ba, da);
        check("pre-reset dz", d, 1'b1);
        @(negedge clk);
        op_a = 8'h48; op_b = 8'h38; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid-DIV reset busy", busy, 1'b0);
        check("mid-DIV reset result", result, 8'h00);
        check("mid-DIV reset done", done, 1'b0);
        check("mid-DIV reset dz", dz, 1'b0);
        check("mid-DIV reset inv", inv, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("mid-DIV reset no done", n_done, 0);
        check("mid-DIV reset idle busy", busy, 1'b0);

        // Start held high across done launches the next operation.
        @(negedge clk);
        op_a = 8'h48; op_b = 8'h38; start = 1'b1;
        @(posedge clk); #1;
        op_a = 8'h30; op_b = 8'h38;
        n_done = 0; seen[0] = 'x; seen[1] = 'x;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (n_done < 2) seen[n_done] = result;
                n_done++;
                if (n_done == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        check("held start first result", seen[0], 8'h40);
        check("held start second result", seen[1], 8'h25);
        check("held start done count", n_done, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_div_8bit_seq.md
FP_DIV_8BIT_SEQ -- requirements
Module: fp_div_8bit_seq

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the block uses this one clock only.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-003 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port: op_a  input  8  dividend, fp8 (sign[7], exp[6:4] bias 3, mant[3:0]).
REQ-005 SHALL have port: op_b  input  8  divisor, same format.
REQ-006 SHALL have port: result  output  8  quotient, held until the next accepted start.
REQ-007 SHALL have port: done  output  1  single-cycle pulse; result valid.
REQ-008 SHALL have port: busy  output  1  high from accept to done, inclusive.
REQ-009 SHALL have port: dz  output  1  divide-by-zero flag, held with result.
REQ-010 SHALL have port: inv  output  1  invalid-operation flag (NaN result), held with result.

Function
REQ-011 SHALL decode operands as: zero = bits[6:0]==0; inf = exp 7 and mant 0; NaN = exp 7 and mant !=0; subnormal = exp 0 and mant !=0 (hidden bit 0, effective exp 1).
REQ-012 SHALL normalize subnormals at accept: left-shift 5-bit significand by lz until bit4=1; effective exp = 1-lz.
REQ-013 SHALL resolve specials in priority order: either NaN, 0/0 or inf/inf -> 8'h78 with inv=1; a inf or b zero -> {sign,111,0000}, dz=1 only when b zero; a zero or b inf -> 8'h00.
REQ-014 SHALL set sign = op_a[7] ^ op_b[7] for non-zero results; zero results SHALL be 8'h00.
REQ-015 SHALL have FSM states IDLE, DIV, PACK; IDLE+start -> DIV (normal) or PACK (special); DIV -> PACK after 6 cycles; PACK -> IDLE.
REQ-016 SHALL compute q = floor(sig_a*32/sig_b) (6 bits) by restoring division, one quotient bit per DIV cycle MSB first, using a 6-bit remainder and no rounding.
REQ-017 SHALL form e = ea - eb + 3 in 6-bit signed; if q[5]=1 mant=q[4:1], else mant=q[3:0] and e=e-1.
REQ-018 SHALL output {sign,111,0000} when e>=7 (overflow, no flag).
REQ-019 SHALL output {sign,000,low4({1,mant} >> (1-e))} when e<=0; when 1-e>=5 it SHALL output 8'h00.
REQ-020 SHALL give done for a start sampled at edge N after edge N+7 (normal) or after edge N+1 (special), for exactly one cycle.
REQ-021 SHALL ignore start while busy; start held high in IDLE after done SHALL begin a new operation.
REQ-022 SHALL capture op_a/op_b at accept; later input changes SHALL NOT affect the operation in flight.
REQ-023 SHALL keep dz and inv unchanged with result until the next done.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-DIV, force IDLE, result=8'h00, done=0, busy=0, dz=0, inv=0 and clear the datapath registers.
REQ-025 SHALL NOT accept start in the cycle where rst_n deasserts; first accept SHALL be at the following edge.

Structure
REQ-026 SHALL place in shared package fp8_pkg: field widths, BIAS=3, FP8_INF=8'h70, FP8_QNAN=8'h78, FP8_ZERO=8'h00 and the FSM state enum.
REQ-027 SHALL use one combinational sub-module fp8_unpack (classify + subnormal normalize + effective exponent), reusable by the multiplier.

Verification
REQ-028 SHALL cover: 0x48/0x38 (3.0/1.5) -> result 0x40, done after edge N+7, dz=0, inv=0.
REQ-029 SHALL cover: 0x30/0x38 -> 0x25 (truncated); 0xC8/0x38 -> 0xC0.
REQ-030 SHALL cover: 0x30/0x00 -> 0x70, dz=1, done after edge N+1; 0x00/0x00 -> 0x78, inv=1.
REQ-031 SHALL cover: 0x6F/0x10 -> 0x70 (overflow); 0x10/0x6F -> 0x01 (subnormal); 0x01/0x6F -> 0x00.
REQ-032 SHALL cover: start pulsed during DIV is ignored (result unchanged, one done); rst_n low mid-DIV -> busy=0, result=0x00, no done.
